// File: rtl/sample_rr_arbiter.sv
// Round-robin arbiter that multiplexes NUM_REQ valid/ready byte streams onto one
// registered output beat, granting bursts of up to MAX_BURST beats per owner.
module sample_rr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                        clk_in,
  input  logic                        rst_low_in,
  input  logic [NUM_REQ-1:0]          req_valid_in,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data_in,
  output logic [NUM_REQ-1:0]          req_ready_out,
  output logic                        data_valid_out,
  output logic [DATA_W-1:0]           data_out,
  input  logic                        data_ready_in,
  output logic [NUM_REQ-1:0]          grant_out,
  output logic                        busy_out
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   owner;
  logic [CW-1:0]   count;

  logic            found;
  logic [PW-1:0]   pick_idx;
  logic            owner_valid;
  logic            slot_free;
  logic            accept;
  logic            last_beat;
  logic [PW-1:0]   next_ptr;

  // Search starts at the pointer and wraps, so the previous owner is checked last.
  always_comb begin
    int unsigned cand;
    found    = 1'b0;
    pick_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req_valid_in[PW'(cand)]) begin
        found    = 1'b1;
        pick_idx = PW'(cand);
      end
    end
  end

  assign owner_valid = req_valid_in[owner];
  assign slot_free   = !data_valid_out || data_ready_in;
  assign accept      = (state == GRANT) && owner_valid && slot_free;
  assign last_beat   = (count == CW'(MAX_BURST - 1));
  assign next_ptr    = (owner == PW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

  always_comb begin
    req_ready_out = '0;
    if (state == GRANT) req_ready_out[owner] = slot_free;
  end

  always_ff @(posedge clk_in or negedge rst_low_in) begin
    if (!rst_low_in) begin
      state          <= IDLE;
      ptr            <= '0;
      owner          <= '0;
      count          <= '0;
      grant_out      <= '0;
      busy_out       <= 1'b0;
      data_valid_out <= 1'b0;
      data_out       <= '0;
    end else begin
      // Output slot: a new accept overrides a drain so back-to-back beats stream.
      if (accept) begin
        data_out       <= req_data_in[owner*DATA_W +: DATA_W];
        data_valid_out <= 1'b1;
      end else if (data_valid_out && data_ready_in) begin
        data_valid_out <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (found) begin
            state     <= GRANT;
            owner     <= pick_idx;
            grant_out <= NUM_REQ'(1) << pick_idx;
            busy_out  <= 1'b1;
            count     <= '0;
          end
        end
        GRANT: begin
          if (!owner_valid || (accept && last_beat)) begin
            state     <= IDLE;
            grant_out <= '0;
            busy_out  <= 1'b0;
            ptr       <= next_ptr;
          end else if (accept) begin
            count <= count + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_rr_arbiter.sv
// Directed bench for sample_rr_arbiter: reset, burst limit, rotation, backpressure,
// early release and pointer wrap, with hand-computed expected values.
module tb_sample_rr_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic               clk_in = 1'b0;
  logic               rst_low_in;
  logic [N-1:0]       req_valid_in;
  logic [N*W-1:0]     req_data_in;
  logic [N-1:0]       req_ready_out;
  logic               data_valid_out;
  logic [W-1:0]       data_out;
  logic               data_ready_in;
  logic [N-1:0]       grant_out;
  logic               busy_out;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0]   q [N][16];
  int           len [N];
  int           pos [N];
  logic [N-1:0] acc;

  always #5 clk_in = ~clk_in;

  sample_rr_arbiter #(.NUM_REQ(N), .DATA_W(W), .MAX_BURST(4)) dut (
    .clk_in         (clk_in),
    .rst_low_in     (rst_low_in),
    .req_valid_in   (req_valid_in),
    .req_data_in    (req_data_in),
    .req_ready_out  (req_ready_out),
    .data_valid_out (data_valid_out),
    .data_out       (data_out),
    .data_ready_in  (data_ready_in),
    .grant_out      (grant_out),
    .busy_out       (busy_out)
  );

  // Requester i presents n beats: base, base+step, ...; holds each until accepted.
  task automatic load(input int i, input int n, input logic [7:0] base, input logic [7:0] step);
    for (int k = 0; k < 16; k++) q[i][k] = base + 8'(k) * step;
    len[i] = n;
    pos[i] = 0;
    req_data_in[i*W +: W] = q[i][0];
    req_valid_in[i] = 1'b1;
  endtask

  // Advance one clock; requesters step their data after a handshake.
  task automatic tick();
    @(negedge clk_in);
    acc = req_valid_in & req_ready_out;
    @(posedge clk_in);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        pos[i]++;
        if (pos[i] >= len[i]) req_valid_in[i] = 1'b0;
        else req_data_in[i*W +: W] = q[i][pos[i]];
      end
    end
  endtask

  task automatic apply_reset();
    rst_low_in    = 1'b0;
    req_valid_in  = '0;
    req_data_in   = '0;
    data_ready_in = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    rst_low_in = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    tests_run++;
    if ({grant_out, busy_out, data_valid_out, data_out, req_ready_out} !== 18'h0) begin
      tests_failed++;
      $display("FAIL reset_idle: got %b expected all zero",
               {grant_out, busy_out, data_valid_out, data_out, req_ready_out});
    end
    load(1, 16, 8'hC1, 8'h01);
    tick(); tick(); tick();
    tests_run++;
    if ({grant_out, data_valid_out, data_out} !== {4'b0010, 1'b1, 8'hC2}) begin
      tests_failed++;
      $display("FAIL reset_preburst: got %b/%b/%h expected 0010/1/c2", grant_out, data_valid_out, data_out);
    end
    #2 rst_low_in = 1'b0;
    #1;
    tests_run++;
    if ({grant_out, busy_out, data_valid_out, data_out, req_ready_out} !== 18'h0) begin
      tests_failed++;
      $display("FAIL reset_async: got %b expected all zero",
               {grant_out, busy_out, data_valid_out, data_out, req_ready_out});
    end
    load(1, 16, 8'h61, 8'h01);
    load(3, 16, 8'h81, 8'h01);
    rst_low_in = 1'b1;
    tick();
    tests_run++;
    if ({grant_out, busy_out} !== {4'b0010, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_first_grant: got %b/%b expected 0010/1", grant_out, busy_out);
    end
    tick();
    tests_run++;
    if ({data_valid_out, data_out} !== {1'b1, 8'h61}) begin
      tests_failed++;
      $display("FAIL reset_first_beat: got %b/%h expected 1/61", data_valid_out, data_out);
    end
  endtask

  task automatic test_single();
    logic [14:0] exp [8];
    exp = '{ {4'b0100, 1'b1, 1'b0, 8'h00}, {4'b0100, 1'b1, 1'b1, 8'h11},
             {4'b0100, 1'b1, 1'b1, 8'h22}, {4'b0100, 1'b1, 1'b1, 8'h33},
             {4'b0000, 1'b0, 1'b1, 8'h44}, {4'b0100, 1'b1, 1'b0, 8'h44},
             {4'b0100, 1'b1, 1'b1, 8'h55}, {4'b0000, 1'b0, 1'b0, 8'h55} };
    apply_reset();
    load(2, 5, 8'h11, 8'h11);
    for (int t = 0; t < 8; t++) begin
      tick();
      tests_run++;
      if ({grant_out, busy_out, data_valid_out, data_out} !== exp[t]) begin
        tests_failed++;
        $display("FAIL single_cycle%0d: got %b expected %b", t + 1,
                 {grant_out, busy_out, data_valid_out, data_out}, exp[t]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] oh;
    logic [7:0] d;
    apply_reset();
    for (int i = 0; i < N; i++) load(i, 16, 8'(i << 4), 8'h01);
    for (int r = 0; r < 5; r++) begin
      oh = 4'b0001 << (r % 4);
      tick();
      tests_run++;
      if ({grant_out, busy_out, data_valid_out} !== {oh, 1'b1, 1'b0}) begin
        tests_failed++;
        $display("FAIL rr_grant%0d: got %b/%b/%b expected %b/1/0", r,
                 grant_out, busy_out, data_valid_out, oh);
      end
      for (int b = 0; b < 4; b++) begin
        tick();
        d = 8'(((r % 4) << 4) | ((r / 4) * 4 + b));
        tests_run++;
        if ({grant_out, data_valid_out, data_out} !== {(b < 3) ? oh : 4'b0000, 1'b1, d}) begin
          tests_failed++;
          $display("FAIL rr_beat%0d_%0d: got %b/%b/%h expected %b/1/%h", r, b,
                   grant_out, data_valid_out, data_out, (b < 3) ? oh : 4'b0000, d);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] seq [3];
    seq = '{8'hB6, 8'hC7, 8'hD8};
    apply_reset();
    load(1, 5, 8'hA5, 8'h11);
    tick();
    tick();
    tests_run++;
    if ({grant_out, data_valid_out, data_out} !== {4'b0010, 1'b1, 8'hA5}) begin
      tests_failed++;
      $display("FAIL bp_first: got %b/%b/%h expected 0010/1/a5", grant_out, data_valid_out, data_out);
    end
    data_ready_in = 1'b0;
    #1;
    tests_run++;
    if (req_ready_out !== 4'b0000) begin
      tests_failed++;
      $display("FAIL bp_ready_low: got %b expected 0000", req_ready_out);
    end
    for (int t = 0; t < 3; t++) begin
      tick();
      tests_run++;
      if ({grant_out, data_valid_out, data_out, req_ready_out} !== {4'b0010, 1'b1, 8'hA5, 4'b0000}) begin
        tests_failed++;
        $display("FAIL bp_hold%0d: got %b/%b/%h/%b expected 0010/1/a5/0000", t,
                 grant_out, data_valid_out, data_out, req_ready_out);
      end
    end
    data_ready_in = 1'b1;
    #1;
    tests_run++;
    if (req_ready_out !== 4'b0010) begin
      tests_failed++;
      $display("FAIL bp_ready_resume: got %b expected 0010", req_ready_out);
    end
    for (int t = 0; t < 3; t++) begin
      tick();
      tests_run++;
      if ({grant_out, data_valid_out, data_out} !== {(t < 2) ? 4'b0010 : 4'b0000, 1'b1, seq[t]}) begin
        tests_failed++;
        $display("FAIL bp_resume%0d: got %b/%b/%h expected %b/1/%h", t,
                 grant_out, data_valid_out, data_out, (t < 2) ? 4'b0010 : 4'b0000, seq[t]);
      end
    end
  endtask

  task automatic test_early_release();
    logic [12:0] exp [6];
    exp = '{ {4'b0010, 1'b0, 8'h00}, {4'b0010, 1'b1, 8'h31}, {4'b0010, 1'b1, 8'h32},
             {4'b0000, 1'b0, 8'h32}, {4'b1000, 1'b0, 8'h32}, {4'b1000, 1'b1, 8'h71} };
    apply_reset();
    load(1, 2, 8'h31, 8'h01);
    load(3, 16, 8'h71, 8'h01);
    for (int t = 0; t < 6; t++) begin
      tick();
      tests_run++;
      if ({grant_out, data_valid_out, data_out} !== exp[t]) begin
        tests_failed++;
        $display("FAIL early_cycle%0d: got %b expected %b", t + 1,
                 {grant_out, data_valid_out, data_out}, exp[t]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [12:0] exp [5];
    exp = '{ {4'b0001, 1'b0, 8'hE1}, {4'b0001, 1'b1, 8'h0A}, {4'b0000, 1'b0, 8'h0A},
             {4'b0100, 1'b0, 8'h0A}, {4'b0100, 1'b1, 8'h2A} };
    apply_reset();
    load(2, 1, 8'hE1, 8'h00);
    tick(); tick(); tick();
    tests_run++;
    if ({grant_out, data_valid_out, data_out} !== {4'b0000, 1'b0, 8'hE1}) begin
      tests_failed++;
      $display("FAIL wrap_setup: got %b/%b/%h expected 0000/0/e1", grant_out, data_valid_out, data_out);
    end
    load(0, 1, 8'h0A, 8'h00);
    load(2, 1, 8'h2A, 8'h00);
    for (int t = 0; t < 5; t++) begin
      tick();
      tests_run++;
      if ({grant_out, data_valid_out, data_out} !== exp[t]) begin
        tests_failed++;
        $display("FAIL wrap_cycle%0d: got %b expected %b", t + 1,
                 {grant_out, data_valid_out, data_out}, exp[t]);
      end
    end
  endtask

  initial begin
    rst_low_in    = 1'b0;
    req_valid_in  = '0;
    req_data_in   = '0;
    data_ready_in = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_early_release();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sample_rr_arbiter.md
Name: sample_rr_arbiter

Overview:
Round-robin arbiter that shares the single 8-bit sample register path between NUM_REQ requesters.
- Each requester presents byte beats on a valid/ready handshake.
- The arbiter grants one owner at a time for a burst of up to MAX_BURST beats.
- It forwards accepted beats through a one-entry output register to the sample datapath, which applies valid/ready backpressure.

Parameters:
NUM_REQ, 4, number of requesters (>=1)
DATA_W, 8, beat width in bits
MAX_BURST, 4, max beats accepted per grant before the owner must release (>=1)

Ports:
clk_in  input  1  single clock, all state on rising edge
rst_low_in  input  1  reset, asynchronous assert, active-low
req_valid_in  input  NUM_REQ  per-requester beat valid
req_data_in  input  NUM_REQ*DATA_W  requester i data in bits [i*DATA_W +: DATA_W]
req_ready_out  output  NUM_REQ  per-requester beat accept
data_valid_out  output  1  output beat valid (registered)
data_out  output  DATA_W  output beat data (registered)
data_ready_in  input  1  downstream accepts output beat
grant_out  output  NUM_REQ  one-hot current owner, 0 when idle (registered)
busy_out  output  1  high while a grant is held (registered)

Behaviour:
- Reset (rst_low_in=0, async):
  - state=IDLE, pointer=0, beat count=0.
  - grant_out=0, busy_out=0, data_valid_out=0, data_out=0.
  - Any in-flight output beat is discarded.
- FSM states: IDLE, GRANT.
- IDLE:
  - If no req_valid_in bit is set, stay in IDLE.
  - Otherwise select the first i with req_valid_in[i]=1, searching from pointer upward with wrap (pointer, pointer+1, ..., NUM_REQ-1, 0, ...).
  - Next cycle: state=GRANT, grant_out=onehot(i), busy_out=1, count=0.
  - Arbitration costs exactly 1 cycle. req_ready_out=0 in IDLE.
- GRANT:
  - slot_free = !data_valid_out || data_ready_in.
  - req_ready_out[g] = slot_free, combinational, owner g only; all other bits are 0.
  - A beat is accepted when req_valid_in[g] && req_ready_out[g].
- Beat accept:
  - data_out <= req_data_in[g]; data_valid_out <= 1; count <= count+1.
  - Accept-to-output latency is 1 cycle.
  - Simultaneous output drain and new accept in the same cycle keeps data_valid_out=1 with the new data (full throughput, 1 beat/cycle).
- Output drain without accept: data_valid_out <= 0 on data_valid_out && data_ready_in. data_out holds its last value.
- Backpressure: data_valid_out=1 and data_ready_in=0 holds data_out and data_valid_out stable. No accept occurs, and count is unchanged.
- Release, when either of the following is sampled at a clock edge in GRANT:
  - (a) an accept makes count reach MAX_BURST;
  - (b) req_valid_in[g]=0.
  - On release: state=IDLE, grant_out=0, busy_out=0, pointer=(g+1) mod NUM_REQ.
  - The buffered output beat is still delivered normally after release.
  - Every grant change passes through IDLE, giving 1 bubble cycle.
- Requesters hold valid and data stable until ready. Dropping valid releases the grant even under backpressure.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 grants.
- Width rules:
  - Counter width is clog2(MAX_BURST+1).
  - Pointer width is max(1, clog2(NUM_REQ)); wrap NUM_REQ-1 -> 0.
  - NUM_REQ=1: pointer is constant 0.
  - MAX_BURST=1: strict per-beat round-robin.

Test Plan:
- Reset check: drive rst_low_in=0 mid-burst while data_valid_out=1 -> same-cycle (async) grant_out=0, busy_out=0, data_valid_out=0, data_out=0x00. After release, first grant goes to the lowest valid index.
- Single requester: req_valid_in=4'b0100 with data 0x11,0x22,0x33,0x44,0x55 and data_ready_in=1.
  - grant_out=4'b0100 one cycle after valid.
  - data_out shows 0x11..0x44 on consecutive cycles, then release, 1 IDLE cycle, re-grant, then 0x55.
- Round-robin: all four valid continuously, MAX_BURST=4, data_ready_in=1 -> grant_out sequence 0001,0010,0100,1000,0001, with 4 beats each and one IDLE cycle between grants.
- Backpressure: data_ready_in=0 for 3 cycles after first beat 0xA5.
  - data_out=0xA5 and data_valid_out=1 held for 3 cycles, req_ready_out[g]=0, count frozen.
  - On data_ready_in=1, the next beat is accepted in that same cycle.
- Early release: owner 1 sends 2 beats then drops valid while requester 3 is valid -> release, pointer=2, grant_out=4'b1000 two cycles after the drop. Both beats are delivered.
- Wrap: pointer=3 with requesters 0 and 2 valid -> requester 0 granted first, then 2.
